// File: rtl/oled_char_renderer.sv
// oled_char_renderer
// Turns one character request into a stream of 8-bit OLED column bytes.
// The glyph word is read from an external registered font ROM.
// The first column sits in the top byte of the glyph word, and bit 0 of each byte is the top pixel row.
// Optional feature: define OLED_CHAR_SPACER_EN to append a blank sixth column to every character.
// The blank column is all ones when the character is inverted.
module oled_char_renderer #(
    parameter int ROM_WIDTH  = 40,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic [7:0]            char_code,
    input  logic                  char_hex,
    input  logic                  char_invert,
    output logic                  rom_re,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [ROM_WIDTH-1:0]  rom_data,
    output logic                  col_valid,
    input  logic                  col_ready,
    output logic [7:0]            col_data,
    output logic                  col_last,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

`ifdef OLED_CHAR_SPACER_EN
    localparam logic [2:0] LAST_COL = 3'd5;
`else
    localparam logic [2:0] LAST_COL = 3'd4;
`endif

    localparam logic [7:0] FIRST_PRINTABLE = 8'd32;
    localparam logic [7:0] LAST_PRINTABLE  = 8'd122;

    state_t                 state;
    logic [ROM_WIDTH-1:0]   shift_q;
    logic [2:0]             col_cnt;
    logic                   invert_q;
    logic                   col_xfer;
    logic [7:0]             fill_byte;
    logic [ADDR_WIDTH-1:0]  mapped_addr;

    // Hex digits index the first 16 glyphs directly.
    // Anything outside the printable range falls back to the space glyph.
    function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [7:0] code,
                                                       input logic       hex);
        logic [ADDR_WIDTH-1:0] addr;
        if (hex) begin
            addr = ADDR_WIDTH'(code[3:0]);
        end else if ((code >= FIRST_PRINTABLE) && (code <= LAST_PRINTABLE)) begin
            addr = ADDR_WIDTH'(code);
        end else begin
            addr = ADDR_WIDTH'(FIRST_PRINTABLE);
        end
        return addr;
    endfunction

    // Request-side handshake and status.
    // char_ready is also masked by reset so that it reads low while reset is held.
    assign char_ready  = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign col_data    = shift_q[ROM_WIDTH-1 -: 8];
    assign col_xfer    = col_valid && col_ready;
    assign fill_byte   = {8{invert_q}};
    assign mapped_addr = map_addr(char_code, char_hex);

    // Main controller.
    // The ROM address is registered at accept time and acts as the latched character.
    // The shift register refills from the right with the spacer pattern, so a sixth column falls out naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_re    <= 1'b0;
            rom_addr  <= '0;
            col_valid <= 1'b0;
            col_last  <= 1'b0;
            shift_q   <= '0;
            col_cnt   <= 3'd0;
            invert_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rom_re    <= 1'b0;
                    col_valid <= 1'b0;
                    col_last  <= 1'b0;
                    if (char_valid) begin
                        invert_q <= char_invert;
                        rom_addr <= mapped_addr;
                        rom_re   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    rom_re <= 1'b0;
                    state  <= LOAD;
                end
                LOAD: begin
                    shift_q   <= rom_data ^ {ROM_WIDTH{invert_q}};
                    col_cnt   <= 3'd0;
                    col_valid <= 1'b1;
                    col_last  <= 1'b0;
                    state     <= SEND;
                end
                SEND: begin
                    if (col_xfer) begin
                        shift_q <= {shift_q[ROM_WIDTH-9:0], fill_byte};
                        if (col_cnt == LAST_COL) begin
                            col_valid <= 1'b0;
                            col_last  <= 1'b0;
                            col_cnt   <= 3'd0;
                            state     <= IDLE;
                        end else begin
                            col_cnt  <= col_cnt + 3'd1;
                            col_last <= ((col_cnt + 3'd1) == LAST_COL);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_char_renderer.sv
// tb_oled_char_renderer
// Randomised and directed bench for oled_char_renderer.
// A registered font ROM lives in the bench.
// A queue-based column model predicts every column byte and every handshake signal on every cycle.
// Honours OLED_CHAR_SPACER_EN in the same way as the design.
module tb_oled_char_renderer;

`ifdef OLED_CHAR_SPACER_EN
    localparam int NCOLS = 6;
`else
    localparam int NCOLS = 5;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } col_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  char_code = 8'h00;
    logic        char_hex = 1'b0;
    logic        char_invert = 1'b0;
    logic        rom_re;
    logic [7:0]  rom_addr;
    logic [39:0] rom_data = '0;
    logic        col_valid;
    logic        col_ready = 1'b0;
    logic [7:0]  col_data;
    logic        col_last;
    logic        busy;

    logic [39:0] font [256];
    col_t        expQ [$];
    int          vectorCount = 0;
    int          missCount = 0;
    int          lat = 0;
    logic        modelBusy = 1'b0;
    logic [7:0]  expAddr = 8'h00;
    logic        checkEn = 1'b0;
    logic        randReady = 1'b0;

    oled_char_renderer #(.ROM_WIDTH(40), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_code   (char_code),
        .char_hex    (char_hex),
        .char_invert (char_invert),
        .rom_re      (rom_re),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .col_valid   (col_valid),
        .col_ready   (col_ready),
        .col_data    (col_data),
        .col_last    (col_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Registered font ROM: data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (rom_re) rom_data <= font[rom_addr];
    end

    // Random downstream back-pressure during the random phase.
    always @(posedge clk) begin
        if (randReady) begin
            #1;
            col_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] mapAddr(input logic [7:0] code, input logic hex);
        if (hex) return {4'h0, code[3:0]};
        if (code >= 8'd32 && code <= 8'd122) return code;
        return 8'd32;
    endfunction

    // Reference model and compare process.
    // It sees accepted characters and turns each one into the list of column bytes it must produce.
    // It also tracks the fixed three-cycle accept-to-column latency.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [39:0] glyph;
            col_t        c;
            if (lat > 0) lat--;
            checkOutput("col_valid", {63'd0, col_valid}, {63'd0, (expQ.size() > 0) && (lat == 0)});
            checkOutput("busy", {63'd0, busy}, {63'd0, modelBusy});
            checkOutput("char_ready", {63'd0, char_ready}, {63'd0, !modelBusy && !rst});
            checkOutput("rom_re", {63'd0, rom_re}, {63'd0, lat == 2});
            if (lat == 2) checkOutput("rom_addr", {56'd0, rom_addr}, {56'd0, expAddr});
            if (col_valid && expQ.size() > 0 && lat == 0) begin
                checkOutput("col_data", {56'd0, col_data}, {56'd0, expQ[0].data});
                checkOutput("col_last", {63'd0, col_last}, {63'd0, expQ[0].last});
                if (col_ready && !rst) begin
                    c = expQ.pop_front();
                    if (c.last) modelBusy = 1'b0;
                end
            end
            if (rst) begin
                expQ.delete();
                modelBusy = 1'b0;
                lat = 0;
            end else if (char_valid && char_ready && !modelBusy) begin
                expAddr = mapAddr(char_code, char_hex);
                glyph = font[expAddr] ^ {40{char_invert}};
                for (int i = 0; i < 5; i++) begin
                    c.data = glyph[39 - 8*i -: 8];
                    c.last = (i == NCOLS - 1);
                    expQ.push_back(c);
                end
                if (NCOLS == 6) begin
                    c.data = {8{char_invert}};
                    c.last = 1'b1;
                    expQ.push_back(c);
                end
                modelBusy = 1'b1;
                lat = 3;
            end
        end
    end

    // Present a character and hold it until the block takes it.
    // Returns one tick after the accepting edge.
    task automatic applyStimulus(input logic [7:0] code, input logic hex, input logic inv);
        int  waited = 0;
        logic taken = 1'b0;
        char_code   = code;
        char_hex    = hex;
        char_invert = inv;
        char_valid  = 1'b1;
        while (!taken && waited < 200) begin
            @(negedge clk);
            if (char_ready) taken = 1'b1;
            else waited++;
        end
        if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) checkOutput("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Render one character with col_ready held high, and compare it against hand-computed bytes.
    task automatic directedChar(input string name, input logic [7:0] code, input logic hex,
                                input logic inv, input logic [7:0] wantAddr,
                                input logic [39:0] wantCols, input logic [7:0] wantSpacer);
        logic [7:0] got [6];
        int         n = 0;
        int         lastIdx = -1;
        int         guard = 0;
        logic [7:0] seenAddr = 8'hxx;
        logic [7:0] want;
        col_ready = 1'b1;
        applyStimulus(code, hex, inv);
        while (lastIdx < 0 && guard < 40 && n < 6) begin
            @(negedge clk);
            guard++;
            if (rom_re) seenAddr = rom_addr;
            if (col_valid && col_ready) begin
                got[n] = col_data;
                if (col_last) lastIdx = n;
                n++;
            end
        end
        checkOutput({name, "_addr"}, {56'd0, seenAddr}, {56'd0, wantAddr});
        checkOutput({name, "_count"}, 64'(n), 64'(NCOLS));
        checkOutput({name, "_lastidx"}, 64'(lastIdx), 64'(NCOLS - 1));
        for (int i = 0; i < n && i < NCOLS; i++) begin
            want = (i < 5) ? wantCols[39 - 8*i -: 8] : wantSpacer;
            checkOutput({name, "_byte"}, {56'd0, got[i]}, {56'd0, want});
        end
        waitIdle();
    endtask

    initial begin
        logic [7:0] code;
        logic       hex;
        int         guard;
        logic [7:0] restCols [4];

        for (int i = 0; i < 256; i++) font[i] = {$urandom, 8'($urandom)};
        font[10] = 40'h7C12_1112_7C;
        font[32] = 40'h00_0000_0000;
        font[48] = 40'h3E_5149_453E;
        font[65] = 40'h7C12_1112_7C;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_char_ready", {63'd0, char_ready}, 64'd0);
        checkOutput("rst_col_valid", {63'd0, col_valid}, 64'd0);
        checkOutput("rst_col_data", {56'd0, col_data}, 64'd0);
        checkOutput("rst_col_last", {63'd0, col_last}, 64'd0);
        checkOutput("rst_rom_re", {63'd0, rom_re}, 64'd0);
        checkOutput("rst_rom_addr", {56'd0, rom_addr}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_char_ready", {63'd0, char_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Hand-computed renders.
        directedChar("char_A", 8'h41, 1'b0, 1'b0, 8'd65, 40'h7C12_1112_7C, 8'h00);
        directedChar("hex_A", 8'h0A, 1'b1, 1'b0, 8'd10, 40'h7C12_1112_7C, 8'h00);
        directedChar("del", 8'h7F, 1'b0, 1'b0, 8'd32, 40'h0, 8'h00);
        directedChar("ctl10", 8'h10, 1'b0, 1'b0, 8'd32, 40'h0, 8'h00);
        directedChar("inv_0", 8'h30, 1'b0, 1'b1, 8'd48, 40'hC1AE_B6BA_C1, 8'hFF);

        // Back-pressure held for four cycles on the second column of 'A'.
        col_ready = 1'b0;
        applyStimulus(8'h41, 1'b0, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!col_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stall_col0", {56'd0, col_data}, 64'h7C);
        @(posedge clk);
        #1;
        col_ready = 1'b1;
        @(posedge clk);
        #1;
        col_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("stall_hold_data", {56'd0, col_data}, 64'h12);
            checkOutput("stall_hold_valid", {63'd0, col_valid}, 64'd1);
            checkOutput("stall_hold_last", {63'd0, col_last}, 64'd0);
            @(posedge clk);
        end
        #1;
        col_ready = 1'b1;
        restCols[0] = 8'h12;
        restCols[1] = 8'h11;
        restCols[2] = 8'h12;
        restCols[3] = 8'h7C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_resume", {56'd0, col_data}, {56'd0, restCols[i]});
        end
        waitIdle();

        // Reset while column 3 of 'A' is on the bus.
        col_ready = 1'b1;
        applyStimulus(8'h41, 1'b0, 1'b0);
        guard = 0;
        @(negedge clk);
        while (!(col_valid && col_data == 8'h12) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_col3", {56'd0, col_data}, 64'h11);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_col_valid", {63'd0, col_valid}, 64'd0);
        checkOutput("midrst_char_ready", {63'd0, char_ready}, 64'd1);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        directedChar("after_rst_A", 8'h41, 1'b0, 1'b0, 8'd65, 40'h7C12_1112_7C, 8'h00);

        // Random traffic with random back-pressure and occasional resets.
        randReady = 1'b1;
        for (int n = 0; n < 80; n++) begin
            hex = 1'b0;
            case ($urandom_range(0, 3))
                0: begin
                    hex  = 1'b1;
                    code = 8'($urandom);
                end
                1: code = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 31))
                                                       : 8'($urandom_range(123, 255));
                default: code = 8'($urandom_range(32, 122));
            endcase
            applyStimulus(code, hex, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 11) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
        end
        randReady = 1'b0;
        @(posedge clk);
        #1;
        col_ready = 1'b1;
        waitIdle();
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/oled_char_renderer.md
OLED_CHAR_RENDERER -- requirements
Module: oled_char_renderer

Interface
REQ-001 SHALL have parameter ROM_WIDTH, default 40, meaning font glyph word width (5 columns x 8 bits).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning font ROM address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 char_valid  input  1  character request valid.
REQ-006 char_ready  output  1  block can accept a character.
REQ-007 char_code  input  8  ASCII code, or hex nibble in bits [3:0] when char_hex=1.
REQ-008 char_hex  input  1  interpret char_code[3:0] as hex digit 0-F.
REQ-009 char_invert  input  1  invert all pixel bits of this character.
REQ-010 rom_re  output  1  font ROM read enable.
REQ-011 rom_addr  output  ADDR_WIDTH  font ROM address.
REQ-012 rom_data  input  ROM_WIDTH  font ROM registered read data, valid one cycle after rom_re.
REQ-013 col_valid  output  1  column byte valid.
REQ-014 col_ready  input  1  downstream accepts column byte.
REQ-015 col_data  output  8  column pixel byte, bit0 = top row.
REQ-016 col_last  output  1  marks final column of the current character.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM SHALL have states IDLE, FETCH, LOAD, SEND.
REQ-019 IDLE: char_ready=1; on char_valid&char_ready latch char_code, char_hex, char_invert; go FETCH.
REQ-020 FETCH (1 cycle): rom_re=1, rom_addr=mapped address; go LOAD. rom_re=0 in all other states.
REQ-021 Mapping: char_hex=1 -> {0,char_code[3:0]}; else code 32..122 -> code; any other code -> 32 (space).
REQ-022 LOAD (1 cycle): capture rom_data into a 40-bit shift register, XOR 40'hFF..FF if invert latched; reset column counter to 0; go SEND.
REQ-023 SEND: col_valid=1, col_data=shift[39:32]; on col_valid&col_ready shift left 8 and increment counter.
REQ-024 col_last=1 on the final column (index 4, or index 5 with spacer); its transfer returns FSM to IDLE.
REQ-025 With col_ready=0, col_data, col_last and state SHALL hold unchanged.
REQ-026 Minimum latency: char accept to first col_valid = 3 cycles; one column per cycle under continuous col_ready.
REQ-027 char_ready SHALL be 0 outside IDLE; requests then are not accepted and SHALL be held by the source.

Reset
REQ-028 rst SHALL force IDLE in the next cycle from any state, including mid-SEND, discarding the character.
REQ-029 Reset values: char_ready=0 during reset then 1, col_valid=0, col_data=0, col_last=0, rom_re=0, rom_addr=0, busy=0, shift register and counter 0.

Configuration
REQ-030 Macro OLED_CHAR_SPACER_EN defined: a 6th column (8'h00, or 8'hFF if inverted) SHALL be emitted after the 5 glyph columns, carrying col_last.
REQ-031 Macro undefined: exactly 5 columns per character, col_last on column 5.

Verification
REQ-032 char_code=8'h41, hex=0, invert=0, col_ready=1 -> rom_addr=65; col_data 7C,12,11,12,7C (+00 with spacer), col_last on final byte.
REQ-033 char_hex=1, char_code=8'h0A -> rom_addr=10; bytes 7C,12,11,12,7C.
REQ-034 char_code=8'h7F, then 8'h10 -> rom_addr=32 both; five 8'h00 bytes each.
REQ-035 char_code=8'h30, invert=1 -> bytes C1,AE,B6,BA,C1 (+FF with spacer).
REQ-036 col_ready low 4 cycles on column 2 of 'A' -> col_data holds 8'h12, col_valid stays 1; stream resumes correctly.
REQ-037 rst asserted during column 3 -> next cycle IDLE, col_valid=0, char_ready=1; next char renders fully.
